// File: rtl/oq_header_inserter_pkg.sv
// rtl/oq_header_inserter_pkg.sv - shared IOQ header layout, FSM states and helper functions
package oq_header_inserter_pkg;

    localparam int IO_QUEUE_STAGE_NUM = 'hff;
    localparam int IOQ_BYTE_LEN_POS   = 0;
    localparam int IOQ_SRC_PORT_POS   = 16;
    localparam int IOQ_WORD_LEN_POS   = 32;
    localparam int IOQ_DST_PORT_POS   = 48;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_HDR,
        OUT_PAYLOAD
    } out_state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // EOP ctrl marks the last valid byte, MSB first; malformed values count as a full word.
    function automatic logic [3:0] valid_bytes(input logic [7:0] ctrl);
        case (ctrl)
            8'h80:   return 4'd1;
            8'h40:   return 4'd2;
            8'h20:   return 4'd3;
            8'h10:   return 4'd4;
            8'h08:   return 4'd5;
            8'h04:   return 4'd6;
            8'h02:   return 4'd7;
            8'h01:   return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// rtl/fallthrough_small_fifo.sv - show-ahead FIFO, head entry visible on dout while not empty
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   count;
    logic                      do_wr;
    logic                      do_rd;

    // count never exceeds DEPTH, so its MSB alone flags full
    assign full  = count[MAX_DEPTH_BITS];
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (MAX_DEPTH_BITS + 1)'(1);
                2'b01:   count <= count - (MAX_DEPTH_BITS + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oq_header_inserter.sv
// rtl/oq_header_inserter.sv - store-and-forward packet buffer that prepends an IOQ module header
module oq_header_inserter
    import oq_header_inserter_pkg::*;
#(
    parameter int DATA_WIDTH           = 64,
    parameter int CTRL_WIDTH           = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM),
    parameter int NUM_OUTPUT_QUEUES    = 8,
    parameter int NUM_OQ_WIDTH         = log2(NUM_OUTPUT_QUEUES),
    parameter int MAX_PKT              = 2048,
    parameter int PKT_BYTE_CNT_WIDTH   = log2(MAX_PKT) + 1,
    parameter int PKT_WORD_CNT_WIDTH   = log2(MAX_PKT / CTRL_WIDTH) + 1,
    parameter int DATA_FIFO_DEPTH_BITS = 9,
    parameter int META_FIFO_DEPTH_BITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl,
    input  logic                    in_wr,
    output logic                    in_rdy,
    input  logic [NUM_OQ_WIDTH-1:0] meta_dst_oq,
    input  logic [15:0]             meta_src_port,
    input  logic                    meta_wr,
    output logic                    meta_rdy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [CTRL_WIDTH-1:0]   out_ctrl,
    output logic                    out_wr,
    input  logic                    out_rdy
);

    localparam int WC       = PKT_WORD_CNT_WIDTH;
    localparam int BC       = PKT_BYTE_CNT_WIDTH;
    localparam int LEN_W    = WC + BC;
    localparam int META_W   = NUM_OQ_WIDTH + 16;
    localparam int DFIFO_W  = CTRL_WIDTH + DATA_WIDTH;

    out_state_t state;
    out_state_t state_next;

    logic               data_full;
    logic               data_empty;
    logic               data_rd;
    logic [DFIFO_W-1:0] data_dout;
    logic               data_eop;

    logic               len_full;
    logic               len_empty;
    logic               len_wr;
    logic [LEN_W-1:0]   len_din;
    logic [LEN_W-1:0]   len_dout;

    logic               meta_full;
    logic               meta_empty;
    logic               meta_push;
    logic [META_W-1:0]  meta_din;
    logic [META_W-1:0]  meta_dout;

    logic               pkt_done;
    logic               hdr_load;
    logic               in_accept;
    logic               in_eop;

    logic [WC-1:0]      word_cnt;
    logic [WC-1:0]      word_total;
    logic [BC-1:0]      bytes_cnt;
    logic [BC-1:0]      bytes_total;
    logic [BC:0]        bytes_sum;
    logic [3:0]         word_bytes;

    logic [DATA_WIDTH-1:0]   hdr_data;
    logic [WC-1:0]           hdr_words;
    logic [BC-1:0]           hdr_bytes;
    logic [NUM_OQ_WIDTH-1:0] hdr_dst;
    logic [15:0]             hdr_src;

    assign in_rdy    = !reset && !data_full && !len_full;
    assign meta_rdy  = !reset && !meta_full;
    assign in_accept = in_wr && in_rdy;
    assign in_eop    = (in_ctrl != '0);
    assign meta_push = meta_wr && meta_rdy;
    assign meta_din  = {meta_dst_oq, meta_src_port};

    // Running totals including the current word; both saturate on oversize packets.
    always_comb begin
        word_bytes  = in_eop ? valid_bytes(in_ctrl) : 4'd8;
        word_total  = (&word_cnt) ? word_cnt : word_cnt + WC'(1);
        bytes_sum   = {1'b0, bytes_cnt} + {{(BC - 3){1'b0}}, word_bytes};
        bytes_total = bytes_sum[BC] ? {BC{1'b1}} : bytes_sum[BC-1:0];
    end

    assign len_wr  = in_accept && in_eop;
    assign len_din = {word_total, bytes_total};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt  <= '0;
            bytes_cnt <= '0;
        end else if (in_accept) begin
            if (in_eop) begin
                word_cnt  <= '0;
                bytes_cnt <= '0;
            end else begin
                word_cnt  <= word_total;
                bytes_cnt <= bytes_total;
            end
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (DFIFO_W),
        .MAX_DEPTH_BITS (DATA_FIFO_DEPTH_BITS)
    ) u_data_fifo (
        .clk   (clk),
        .reset (reset),
        .din   ({in_ctrl, in_data}),
        .wr_en (in_accept),
        .rd_en (data_rd),
        .dout  (data_dout),
        .full  (data_full),
        .empty (data_empty)
    );

    fallthrough_small_fifo #(
        .WIDTH          (LEN_W),
        .MAX_DEPTH_BITS (META_FIFO_DEPTH_BITS)
    ) u_len_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (len_din),
        .wr_en (len_wr),
        .rd_en (pkt_done),
        .dout  (len_dout),
        .full  (len_full),
        .empty (len_empty)
    );

    fallthrough_small_fifo #(
        .WIDTH          (META_W),
        .MAX_DEPTH_BITS (META_FIFO_DEPTH_BITS)
    ) u_meta_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (meta_din),
        .wr_en (meta_push),
        .rd_en (pkt_done),
        .dout  (meta_dout),
        .full  (meta_full),
        .empty (meta_empty)
    );

    assign data_eop = (data_dout[DATA_WIDTH +: CTRL_WIDTH] != '0);

    assign {hdr_words, hdr_bytes} = len_dout;
    assign {hdr_dst, hdr_src}     = meta_dout;

    always_comb begin
        hdr_data = '0;
        hdr_data[IOQ_DST_PORT_POS +: 16] = 16'd1 << hdr_dst;
        hdr_data[IOQ_WORD_LEN_POS +: 16] = 16'(hdr_words);
        hdr_data[IOQ_SRC_PORT_POS +: 16] = hdr_src;
        hdr_data[IOQ_BYTE_LEN_POS +: 16] = 16'(hdr_bytes);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OUT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A length entry only exists once the whole packet sits in the data FIFO,
    // so the payload phase can never starve mid-packet.
    always_comb begin
        state_next = state;
        hdr_load   = 1'b0;
        data_rd    = 1'b0;
        pkt_done   = 1'b0;
        case (state)
            OUT_IDLE: begin
                if (!len_empty && !meta_empty) begin
                    state_next = OUT_HDR;
                end
            end
            OUT_HDR: begin
                if (out_rdy) begin
                    hdr_load   = 1'b1;
                    state_next = OUT_PAYLOAD;
                end
            end
            OUT_PAYLOAD: begin
                if (out_rdy && !data_empty) begin
                    data_rd = 1'b1;
                    if (data_eop) begin
                        pkt_done   = 1'b1;
                        state_next = OUT_IDLE;
                    end
                end
            end
            default: state_next = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= hdr_load || data_rd;
            if (hdr_load) begin
                out_data <= hdr_data;
                out_ctrl <= IOQ_STAGE_NUM;
            end else if (data_rd) begin
                out_data <= data_dout[DATA_WIDTH-1:0];
                out_ctrl <= data_dout[DATA_WIDTH +: CTRL_WIDTH];
            end
        end
    end

endmodule

// File: doc/oq_header_inserter.md
Name: oq_header_inserter

Overview:
- Transmit-side counterpart of the output-queue header parser.
- Accepts a raw packet stream plus per-packet routing metadata (binary destination queue, source port).
- Buffers each packet store-and-forward while counting its words and bytes.
- Emits the packet prefixed with one IOQ module header word (ctrl = `IO_QUEUE_STAGE_NUM`). Sits ahead of the output-queue stage, so downstream parsers find destination, byte length and word length in the header.

Parameters:
- DATA_WIDTH, 64, stream data width.
- CTRL_WIDTH, DATA_WIDTH/8, stream ctrl width.
- IOQ_STAGE_NUM, `IO_QUEUE_STAGE_NUM, ctrl value of the emitted header word.
- NUM_OUTPUT_QUEUES, 8, number of one-hot destination bits.
- NUM_OQ_WIDTH, log2(NUM_OUTPUT_QUEUES), binary destination width.
- MAX_PKT, 2048, maximum packet size in bytes.
- PKT_BYTE_CNT_WIDTH, log2(MAX_PKT)+1, byte counter width (holds 2048).
- PKT_WORD_CNT_WIDTH, log2(MAX_PKT/CTRL_WIDTH)+1, word counter width (holds 256).
- DATA_FIFO_DEPTH_BITS, 9, log2 of payload buffer depth (512 words, at least 2 maximum packets).
- META_FIFO_DEPTH_BITS, 2, log2 of metadata and length FIFO depth.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  payload word.
- in_ctrl  in  CTRL_WIDTH  0 = non-final word; nonzero one-hot = EOP with byte position.
- in_wr  in  1  input word valid.
- in_rdy  out  1  block can accept an input word this cycle.
- meta_dst_oq  in  NUM_OQ_WIDTH  binary destination queue.
- meta_src_port  in  16  source port field.
- meta_wr  in  1  metadata valid.
- meta_rdy  out  1  metadata FIFO not full.
- out_data  out  DATA_WIDTH  output word.
- out_ctrl  out  CTRL_WIDTH  output ctrl.
- out_wr  out  1  output word valid.
- out_rdy  in  1  downstream can accept.

Behaviour:
- Reset (asynchronous, active-high): all FIFOs emptied, counters cleared, FSM to OUT_IDLE.
  - out_wr=0, out_data=0, out_ctrl=0, in_rdy=0, meta_rdy=0 while reset is asserted.
  - Reset mid-packet discards all partial and buffered packets; there is no recovery of partial data.
- Input side:
  - A word is accepted when in_wr && in_rdy; it is written unchanged into the data FIFO.
  - in_rdy = !data_full && !len_full. Writing with in_rdy low is a protocol violation; the word is dropped.
  - word_cnt increments per accepted word and bytes_cnt adds 8 per non-EOP word.
  - On EOP, bytes_cnt adds valid_bytes(in_ctrl): 0x80→1, 0x40→2, 0x20→3, 0x10→4, 0x08→5, 0x04→6, 0x02→7, 0x01→8; any non-one-hot value →8.
  - On EOP, {word_cnt+1, final bytes} is pushed to the length FIFO and both counters clear in the same cycle.
  - Single-word packets (first word is EOP) are legal.
  - Packets over MAX_PKT bytes are unsupported; counters saturate.
- Metadata:
  - Pushed when meta_wr && meta_rdy.
  - Order matches packet order; metadata may arrive before, during or after its packet.
- Output FSM:
  - OUT_IDLE → OUT_HDR when len FIFO and meta FIFO are both non-empty.
  - OUT_HDR: when out_rdy, register the header word:
    - out_ctrl=IOQ_STAGE_NUM, out_wr=1.
    - out_data[`IOQ_DST_PORT_POS+:16] = one-hot(1<<dst_oq).
    - out_data[`IOQ_WORD_LEN_POS+:16] = word count.
    - out_data[`IOQ_SRC_PORT_POS+:16] = src_port.
    - out_data[`IOQ_BYTE_LEN_POS+:16] = byte count.
    - Unused bits are 0. Go to OUT_PAYLOAD.
  - OUT_PAYLOAD: each cycle with out_rdy && !data_empty, pop one word and register it with its ctrl and out_wr=1.
    - Popping the EOP word pops the len and meta FIFOs and returns to OUT_IDLE.
- out_wr is high only in the cycle after out_rdy was sampled high with a word available; otherwise out_wr=0. out_data and out_ctrl hold their last values.
- Latency: the header appears 2 cycles after EOP acceptance when metadata is already present. The header is never emitted before the EOP of its own packet.
- Back-to-back packets: OUT_IDLE lasts exactly one cycle between packets when the next packet is ready.
- Simultaneous EOP push and len pop in the same cycle are both honoured.

Decomposition:
- Shared defines: IOQ field positions and the IO_QUEUE_STAGE_NUM define, from the existing defines file.
- Shared function: valid_bytes(ctrl) and the log2 function, placed in a shared include package. The parser and the inserter share the byte-position encoding.
- Sub-modules: reuse fallthrough_small_fifo three times (data, length, metadata). No new sub-module.

Test Plan:
- 3-word packet (last ctrl 0x20), meta dst_oq=2, src=1 → header 0x0004_0003_0001_0013 with ctrl 0xFF, then 3 payload words unchanged.
- 1-word packet with ctrl 0x01, dst_oq=7 → header dst 0x0080, words=1, bytes=8, followed by 1 payload word.
- Metadata delayed 20 cycles after EOP → no out_wr until metadata arrives; header follows 2 cycles later.
- out_rdy toggled randomly during a 256-word packet → no words lost or duplicated, order preserved, header bytes=2048.
- Fill the data FIFO with out_rdy=0 → in_rdy falls at 512 buffered words; releasing out_rdy drains everything correctly.
- Assert reset mid-payload → out_wr=0 immediately, in_rdy=0, FIFOs empty; a fresh packet after reset is emitted correctly.
